child_rr_scheduler: RTL and testbench

- Round-robin scheduler that shares one resource among the NUM_REQ child instances of a generated root module (default 10, inst_0..inst_9).
- Each child raises req. The scheduler issues a registered one-hot grant. The grant is held until the child pulses done, drops req, or a hold timeout expires.
- Sits beside the child instances inside the root module. It is the only arbitration point for the shared resource.

---
 rtl/child_sched_pkg.sv | 9 +
 rtl/child_rr_scheduler_rr_pick.sv | 27 ++
 rtl/child_rr_scheduler.sv | 111 +++++++++++
 tb/tb_child_rr_scheduler.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/child_sched_pkg.sv
// Shared types and default sizing for the child round-robin scheduler family.
package child_sched_pkg;

  typedef enum logic {IDLE, GRANT} sched_state_t;

  localparam int NUM_REQ_DEF  = 10;
  localparam int HOLD_MAX_DEF = 64;

endpackage

// File: rtl/child_rr_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request after ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 10,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic               found,
  output logic [IDW-1:0]     idx
);

  // Search order ptr+1 .. ptr+NUM_REQ, so ptr itself comes last.
  always_comb begin
    int j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(ptr) + k) % NUM_REQ;
      if (!found && req[j]) begin
        found = 1'b1;
        idx   = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/child_rr_scheduler.sv
// Round-robin single-resource scheduler for generated child instances.
// Optional SCHED_STATS_EN adds a saturating forced-release counter (timeout_cnt).
module child_rr_scheduler
  import child_sched_pkg::*;
#(
  parameter int NUM_REQ  = NUM_REQ_DEF,
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CNT_W    = 16,
  localparam int IDW     = $clog2(NUM_REQ),
  localparam int HCW     = $clog2(HOLD_MAX)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDW-1:0]     gnt_id,
  output logic               busy,
  output logic               timeout
`ifdef SCHED_STATS_EN
  ,
  output logic [CNT_W-1:0]   timeout_cnt
`endif
);

  if (NUM_REQ < 2 || NUM_REQ > 32 || HOLD_MAX < 2 || CNT_W < 1) begin : g_bad_param
    $error("child_rr_scheduler: parameter out of range");
  end

  sched_state_t       state, state_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic [IDW-1:0]     id_n, ptr, ptr_n, pick_idx;
  logic [HCW-1:0]     hold_cnt, hold_n;
  logic               to_n, found, rel_norm, at_limit, forced;

  rr_pick #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .idx   (pick_idx)
  );

  // Only the grantee's done/req bits matter; everything else is ignored.
  assign rel_norm = done[gnt_id] | ~req[gnt_id];
  assign at_limit = (hold_cnt == HCW'(HOLD_MAX - 1));
  assign forced   = (state == GRANT) && !rel_norm && at_limit;
  assign busy     = |gnt;

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    id_n    = gnt_id;
    ptr_n   = ptr;
    hold_n  = hold_cnt;
    to_n    = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          gnt_n           = '0;
          gnt_n[pick_idx] = 1'b1;
          id_n            = pick_idx;
          hold_n          = '0;
          state_n         = GRANT;
        end
      end
      GRANT: begin
        if (rel_norm || at_limit) begin
          gnt_n   = '0;
          id_n    = '0;
          ptr_n   = gnt_id;
          hold_n  = '0;
          to_n    = ~rel_norm;
          state_n = IDLE;
        end else begin
          hold_n = hold_cnt + HCW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      ptr      <= IDW'(NUM_REQ - 1);
      hold_cnt <= '0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      gnt_id   <= id_n;
      ptr      <= ptr_n;
      hold_cnt <= hold_n;
      timeout  <= to_n;
    end
  end

`ifdef SCHED_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      timeout_cnt <= '0;
    else if (forced && timeout_cnt != '1)
      timeout_cnt <= timeout_cnt + CNT_W'(1);
  end
`endif

  a_gnt_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));

endmodule

// File: tb/tb_child_rr_scheduler.sv
// Directed table-driven bench for child_rr_scheduler plus hand-written multi-cycle sequences.
module tb_child_rr_scheduler;

  localparam int N  = 10;
  localparam int HM = 64;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] req = '0;
  logic [N-1:0] done = '0;
  logic [N-1:0] gnt;
  logic [3:0]   gnt_id;
  logic         busy, timeout;
`ifdef SCHED_STATS_EN
  logic [15:0]  timeout_cnt;
`endif

  int total = 0;
  int bad   = 0;

  child_rr_scheduler #(.NUM_REQ(N), .HOLD_MAX(HM), .CNT_W(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
`ifdef SCHED_STATS_EN
    ,
    .timeout_cnt (timeout_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0] req;
    logic [N-1:0] done;
    logic [N-1:0] gnt;
    logic [3:0]   id;
    logic         busy;
  } vec_t;

  vec_t tv [14];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, ".gnt"}, 32'(gnt), 32'h0);
    chk({nm, ".id"}, 32'(gnt_id), 32'h0);
    chk({nm, ".busy"}, 32'(busy), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; done = '0;
    tick(); tick();
    rst = 1'b0;
  endtask

  initial begin
    int cnt;
    // req, done -> gnt, id, busy (timeout expected 0 throughout)
    tv[0]  = '{req:10'h009, done:10'h000, gnt:10'h001, id:4'd0, busy:1'b1};
    tv[1]  = '{req:10'h009, done:10'h000, gnt:10'h001, id:4'd0, busy:1'b1};
    tv[2]  = '{req:10'h009, done:10'h000, gnt:10'h001, id:4'd0, busy:1'b1};
    tv[3]  = '{req:10'h009, done:10'h000, gnt:10'h001, id:4'd0, busy:1'b1};
    tv[4]  = '{req:10'h009, done:10'h001, gnt:10'h000, id:4'd0, busy:1'b0};
    tv[5]  = '{req:10'h009, done:10'h000, gnt:10'h008, id:4'd3, busy:1'b1};
    tv[6]  = '{req:10'h000, done:10'h000, gnt:10'h000, id:4'd0, busy:1'b0};
    tv[7]  = '{req:10'h000, done:10'h000, gnt:10'h000, id:4'd0, busy:1'b0};
    tv[8]  = '{req:10'h080, done:10'h000, gnt:10'h080, id:4'd7, busy:1'b1};
    tv[9]  = '{req:10'h084, done:10'h004, gnt:10'h080, id:4'd7, busy:1'b1};
    tv[10] = '{req:10'h084, done:10'h004, gnt:10'h080, id:4'd7, busy:1'b1};
    tv[11] = '{req:10'h084, done:10'h080, gnt:10'h000, id:4'd0, busy:1'b0};
    tv[12] = '{req:10'h084, done:10'h000, gnt:10'h004, id:4'd2, busy:1'b1};
    tv[13] = '{req:10'h000, done:10'h000, gnt:10'h000, id:4'd0, busy:1'b0};

    do_reset();
    chk_idle("reset");
    chk("reset.timeout", 32'(timeout), 32'h0);
`ifdef SCHED_STATS_EN
    chk("reset.tcnt", 32'(timeout_cnt), 32'h0);
`endif

    for (int i = 0; i < 14; i++) begin
      req = tv[i].req; done = tv[i].done;
      tick();
      chk($sformatf("vec%0d.gnt", i), 32'(gnt), 32'(tv[i].gnt));
      chk($sformatf("vec%0d.id", i), 32'(gnt_id), 32'(tv[i].id));
      chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(tv[i].busy));
      chk($sformatf("vec%0d.to", i), 32'(timeout), 32'h0);
    end

    // Full round robin: order 0..9,0, release on second grant cycle, one idle gap.
    do_reset();
    req = '1;
    for (int n = 0; n < 11; n++) begin
      logic [N-1:0] exp_g;
      exp_g = '0;
      exp_g[n % N] = 1'b1;
      done = '0;
      tick();
      chk($sformatf("rr%0d.gnt", n), 32'(gnt), 32'(exp_g));
      chk($sformatf("rr%0d.id", n), 32'(gnt_id), 32'(n % N));
      tick();
      chk($sformatf("rr%0d.hold", n), 32'(gnt), 32'(exp_g));
      done = exp_g;
      tick();
      chk($sformatf("rr%0d.gap", n), 32'(gnt), 32'h0);
    end
    done = '0;

    // Forced release after exactly HM grant cycles.
    do_reset();
    req = 10'h020;
    tick();
    chk("to.first", 32'(gnt), 32'h020);
    cnt = 0;
    while (gnt[5] && cnt < 200) begin
      cnt++;
      tick();
    end
    chk("to.len", 32'(cnt), 32'(HM));
    chk("to.pulse", 32'(timeout), 32'h1);
    chk("to.gnt0", 32'(gnt), 32'h0);
`ifdef SCHED_STATS_EN
    chk("to.tcnt", 32'(timeout_cnt), 32'h1);
`endif
    tick();
    chk("to.regnt", 32'(gnt), 32'h020);
    chk("to.pulse_end", 32'(timeout), 32'h0);

    // done coincident with the last hold cycle wins over the timeout.
    for (int k = 0; k < HM - 1; k++) tick();
    chk("co.still", 32'(gnt), 32'h020);
    done = 10'h020;
    tick();
    done = '0;
    chk("co.gnt", 32'(gnt), 32'h0);
    chk("co.to", 32'(timeout), 32'h0);
    tick();
    chk("co.to2", 32'(timeout), 32'h0);
`ifdef SCHED_STATS_EN
    chk("co.tcnt", 32'(timeout_cnt), 32'h1);
`endif

    // Reset during a grant drops everything at that edge.
    do_reset();
    req = 10'h080;
    tick();
    chk("rs.gnt7", 32'(gnt), 32'h080);
    tick();
    rst = 1'b1;
    tick();
    chk_idle("rs.mid");
    chk("rs.to", 32'(timeout), 32'h0);
    rst = 1'b0;
    req = 10'h200;
    tick();
    chk("rs.gnt9", 32'(gnt), 32'h200);
    chk("rs.id9", 32'(gnt_id), 32'd9);
    req = '0;
    tick();
    chk("rs.rel", 32'(gnt), 32'h0);
    chk("rs.to2", 32'(timeout), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
